// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the Memory pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int         DATA_W_DEF      = 32;
  localparam int         REG_W_DEF       = 4;
  localparam int         TIMEOUT_CYC_DEF = 64;
  localparam logic [1:0] ALIGN_MASK      = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute/data-memory/writeback/forwarding bundle around the Memory stage.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_alu_out;
  logic [DATA_W-1:0] ex_mem_addr;
  logic [DATA_W-1:0] ex_mem_data;
  logic [REG_W-1:0]  ex_reg_dest;
  logic              ex_reg_wr;
  logic              ex_mem_rd;
  logic              ex_mem_wr;

  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              wb_valid;
  logic              wb_reg_wr;
  logic [REG_W-1:0]  wb_reg_dest;
  logic [DATA_W-1:0] wb_data;

  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_dest;
  logic [DATA_W-1:0] fwd_data;

  logic              err;

  // master: the Memory stage itself
  modport master (
    input  ex_valid, ex_alu_out, ex_mem_addr, ex_mem_data, ex_reg_dest,
           ex_reg_wr, ex_mem_rd, ex_mem_wr, dm_gnt, dm_rvalid, dm_rdata,
    output ex_ready, dm_req, dm_we, dm_addr, dm_wdata, wb_valid, wb_reg_wr,
           wb_reg_dest, wb_data, fwd_valid, fwd_dest, fwd_data, err
  );

  // slave: Execute, data memory and Writeback as seen from the stage
  modport slave (
    output ex_valid, ex_alu_out, ex_mem_addr, ex_mem_data, ex_reg_dest,
           ex_reg_wr, ex_mem_rd, ex_mem_wr, dm_gnt, dm_rvalid, dm_rdata,
    input  ex_ready, dm_req, dm_we, dm_addr, dm_wdata, wb_valid, wb_reg_wr,
           wb_reg_dest, wb_data, fwd_valid, fwd_dest, fwd_data, err
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Saturating access timer; expired is high on the cycle the count hits TIMEOUT_CYC-1.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one op, runs the data-memory handshake, retires to Writeback
// and feeds the forwarding path. Non-memory ops stream through at one per cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.master bus
);
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  dest;
    logic              reg_wr;
    logic              is_store;
  } hold_t;

  state_t            state_q;
  hold_t             hold_q, hold_d;
  logic              wb_valid_q, wb_reg_wr_q, err_q;
  logic [REG_W-1:0]  wb_reg_dest_q;
  logic [DATA_W-1:0] wb_data_q;

  logic in_is_mem, in_misaligned, accept, start_access, expired;

  assign accept        = bus.ex_valid && (state_q == IDLE);
  assign in_is_mem     = bus.ex_mem_rd || bus.ex_mem_wr;
  assign in_misaligned = is_misaligned(bus.ex_mem_addr[1:0]);
  assign start_access  = accept && in_is_mem && !in_misaligned;

  always_comb begin
    hold_d.addr     = bus.ex_mem_addr;
    hold_d.wdata    = bus.ex_mem_data;
    hold_d.dest     = bus.ex_reg_dest;
    hold_d.reg_wr   = bus.ex_reg_wr;
    hold_d.is_store = bus.ex_mem_wr;  // rd+wr together behaves as a store
  end

  mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_access),
    .en_i      ((state_q == REQ) || (state_q == WAIT)),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      wb_valid_q    <= 1'b0;
      wb_reg_wr_q   <= 1'b0;
      wb_reg_dest_q <= '0;
      wb_data_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            hold_q <= hold_d;
            if (!in_is_mem) begin
              wb_valid_q    <= 1'b1;
              wb_reg_wr_q   <= bus.ex_reg_wr;
              wb_reg_dest_q <= bus.ex_reg_dest;
              wb_data_q     <= bus.ex_alu_out;
            end else if (in_misaligned) begin
              wb_valid_q    <= 1'b1;
              err_q         <= 1'b1;
              wb_reg_wr_q   <= 1'b0;
              wb_reg_dest_q <= bus.ex_reg_dest;
              wb_data_q     <= '0;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.dm_gnt) begin
            if (hold_q.is_store) begin
              state_q       <= IDLE;
              wb_valid_q    <= 1'b1;
              wb_reg_wr_q   <= 1'b0;
              wb_reg_dest_q <= hold_q.dest;
              wb_data_q     <= '0;
            end else if (bus.dm_rvalid) begin
              state_q       <= IDLE;
              wb_valid_q    <= 1'b1;
              wb_reg_wr_q   <= hold_q.reg_wr;
              wb_reg_dest_q <= hold_q.dest;
              wb_data_q     <= bus.dm_rdata;
            end else begin
              state_q <= WAIT;
            end
          end else if (expired) begin
            state_q       <= IDLE;
            wb_valid_q    <= 1'b1;
            err_q         <= 1'b1;
            wb_reg_wr_q   <= 1'b0;
            wb_reg_dest_q <= hold_q.dest;
            wb_data_q     <= '0;
          end
        end
        WAIT: begin
          if (bus.dm_rvalid) begin
            state_q       <= IDLE;
            wb_valid_q    <= 1'b1;
            wb_reg_wr_q   <= hold_q.reg_wr;
            wb_reg_dest_q <= hold_q.dest;
            wb_data_q     <= bus.dm_rdata;
          end else if (expired) begin
            state_q       <= IDLE;
            wb_valid_q    <= 1'b1;
            err_q         <= 1'b1;
            wb_reg_wr_q   <= 1'b0;
            wb_reg_dest_q <= hold_q.dest;
            wb_data_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ex_ready    = (state_q == IDLE);
  assign bus.dm_req      = (state_q == REQ);
  assign bus.dm_we       = (state_q == REQ) && hold_q.is_store;
  assign bus.dm_addr     = hold_q.addr;
  assign bus.dm_wdata    = hold_q.wdata;

  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_reg_wr   = wb_reg_wr_q;
  assign bus.wb_reg_dest = wb_reg_dest_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.err         = err_q;

  assign bus.fwd_valid   = wb_valid_q && wb_reg_wr_q;
  assign bus.fwd_dest    = wb_reg_dest_q;
  assign bus.fwd_data    = wb_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with an 8-cycle access timeout.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.DATA_W(32), .REG_W(4)) bus ();

  mem_stage #(.DATA_W(32), .REG_W(4), .TIMEOUT_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ex_valid = 0; bus.ex_alu_out = '0; bus.ex_mem_addr = '0; bus.ex_mem_data = '0;
    bus.ex_reg_dest = '0; bus.ex_reg_wr = 0; bus.ex_mem_rd = 0; bus.ex_mem_wr = 0;
    bus.dm_gnt = 0; bus.dm_rvalid = 0; bus.dm_rdata = '0;
  endtask

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] dest, input logic rw, input logic rd, input logic wr);
    bus.ex_valid = 1; bus.ex_alu_out = alu; bus.ex_mem_addr = addr; bus.ex_mem_data = data;
    bus.ex_reg_dest = dest; bus.ex_reg_wr = rw; bus.ex_mem_rd = rd; bus.ex_mem_wr = wr;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1; tick(); tick(); rst = 0;
    vec++; if (bus.ex_ready !== 1'b1) begin miss++; $display("FAIL reset ex_ready: got %b exp 1", bus.ex_ready); end
    vec++; if (bus.dm_req !== 1'b0 || bus.dm_we !== 1'b0) begin miss++; $display("FAIL reset dm_req/we: got %b/%b exp 0/0", bus.dm_req, bus.dm_we); end
    vec++; if (bus.dm_addr !== 32'h0 || bus.dm_wdata !== 32'h0) begin miss++; $display("FAIL reset dm_addr/wdata: got %h/%h exp 0/0", bus.dm_addr, bus.dm_wdata); end
    vec++; if (bus.wb_valid !== 1'b0 || bus.wb_reg_wr !== 1'b0 || bus.err !== 1'b0) begin miss++; $display("FAIL reset wb_valid/reg_wr/err: got %b%b%b exp 000", bus.wb_valid, bus.wb_reg_wr, bus.err); end
    vec++; if (bus.wb_reg_dest !== 4'h0 || bus.wb_data !== 32'h0) begin miss++; $display("FAIL reset wb_dest/data: got %h/%h exp 0/0", bus.wb_reg_dest, bus.wb_data); end
  endtask

  task automatic test_alu_passthru();
    logic [31:0] alu_v;
    for (int i = 1; i <= 3; i++) begin
      alu_v = 32'h11 * i;
      drive_op(alu_v, 32'h0, 32'h0, 4'(i), 1'b1, 1'b0, 1'b0);
      tick();
      vec++; if (bus.wb_valid !== 1'b1 || bus.wb_reg_dest !== 4'(i) || bus.wb_data !== alu_v)
        begin miss++; $display("FAIL alu wb op%0d: got v=%b d=%h data=%h exp v=1 d=%h data=%h", i, bus.wb_valid, bus.wb_reg_dest, bus.wb_data, 4'(i), alu_v); end
      vec++; if (bus.ex_ready !== 1'b1) begin miss++; $display("FAIL alu ex_ready op%0d: got %b exp 1", i, bus.ex_ready); end
      vec++; if (bus.fwd_valid !== 1'b1 || bus.fwd_data !== alu_v) begin miss++; $display("FAIL alu fwd op%0d: got v=%b data=%h exp v=1 data=%h", i, bus.fwd_valid, bus.fwd_data, alu_v); end
    end
    drive_idle(); tick();
    vec++; if (bus.wb_valid !== 1'b0) begin miss++; $display("FAIL alu wb_valid after stream: got %b exp 0", bus.wb_valid); end
  endtask

  task automatic test_store_delayed_gnt();
    drive_op(32'h0, 32'h100, 32'hDEADBEEF, 4'h4, 1'b0, 1'b0, 1'b1);
    tick(); drive_idle();
    for (int k = 0; k < 4; k++) begin
      vec++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b1 || bus.dm_addr !== 32'h100 || bus.dm_wdata !== 32'hDEADBEEF)
        begin miss++; $display("FAIL store req cyc%0d: got req=%b we=%b a=%h d=%h exp 1 1 100 deadbeef", k, bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_wdata); end
      vec++; if (bus.ex_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin miss++; $display("FAIL store busy cyc%0d: got rdy=%b wbv=%b exp 0 0", k, bus.ex_ready, bus.wb_valid); end
      if (k == 3) bus.dm_gnt = 1;
      tick();
    end
    bus.dm_gnt = 0;
    vec++; if (bus.wb_valid !== 1'b1 || bus.wb_reg_wr !== 1'b0 || bus.err !== 1'b0)
      begin miss++; $display("FAIL store retire: got v=%b rw=%b err=%b exp 1 0 0", bus.wb_valid, bus.wb_reg_wr, bus.err); end
    vec++; if (bus.dm_req !== 1'b0 || bus.ex_ready !== 1'b1) begin miss++; $display("FAIL store idle: got req=%b rdy=%b exp 0 1", bus.dm_req, bus.ex_ready); end
    tick();
    vec++; if (bus.wb_valid !== 1'b0) begin miss++; $display("FAIL store single pulse: got %b exp 0", bus.wb_valid); end
  endtask

  task automatic test_load_same_cycle();
    drive_op(32'h0, 32'h200, 32'h0, 4'h5, 1'b1, 1'b1, 1'b0);
    tick(); drive_idle();
    vec++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b0 || bus.dm_addr !== 32'h200)
      begin miss++; $display("FAIL load req: got req=%b we=%b a=%h exp 1 0 200", bus.dm_req, bus.dm_we, bus.dm_addr); end
    bus.dm_gnt = 1; bus.dm_rvalid = 1; bus.dm_rdata = 32'hCAFEF00D;
    tick();
    bus.dm_gnt = 0; bus.dm_rvalid = 0; bus.dm_rdata = '0;
    vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hCAFEF00D || bus.wb_reg_wr !== 1'b1)
      begin miss++; $display("FAIL load retire: got v=%b data=%h rw=%b exp 1 cafef00d 1", bus.wb_valid, bus.wb_data, bus.wb_reg_wr); end
    vec++; if (bus.fwd_valid !== 1'b1 || bus.fwd_dest !== 4'h5 || bus.fwd_data !== 32'hCAFEF00D)
      begin miss++; $display("FAIL load fwd: got v=%b d=%h data=%h exp 1 5 cafef00d", bus.fwd_valid, bus.fwd_dest, bus.fwd_data); end
    tick();
    vec++; if (bus.wb_valid !== 1'b0 || bus.fwd_valid !== 1'b0) begin miss++; $display("FAIL load single pulse: got %b/%b exp 0/0", bus.wb_valid, bus.fwd_valid); end
  endtask

  task automatic test_load_wait();
    drive_op(32'h0, 32'h300, 32'h0, 4'h6, 1'b1, 1'b1, 1'b0);
    tick(); drive_idle();
    // a response with no grant must be ignored in REQ
    bus.dm_rvalid = 1; bus.dm_rdata = 32'hBADBAD00;
    tick();
    bus.dm_rvalid = 0; bus.dm_rdata = '0;
    vec++; if (bus.wb_valid !== 1'b0 || bus.dm_req !== 1'b1) begin miss++; $display("FAIL rvalid w/o gnt: got wbv=%b req=%b exp 0 1", bus.wb_valid, bus.dm_req); end
    bus.dm_gnt = 1; tick(); bus.dm_gnt = 0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (bus.dm_req !== 1'b0 || bus.ex_ready !== 1'b0 || bus.wb_valid !== 1'b0)
        begin miss++; $display("FAIL wait cyc%0d: got req=%b rdy=%b wbv=%b exp 0 0 0", k, bus.dm_req, bus.ex_ready, bus.wb_valid); end
      tick();
    end
    bus.dm_rvalid = 1; bus.dm_rdata = 32'h12345678;
    tick();
    bus.dm_rvalid = 0; bus.dm_rdata = '0;
    vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h12345678 || bus.wb_reg_dest !== 4'h6 || bus.wb_reg_wr !== 1'b1 || bus.err !== 1'b0)
      begin miss++; $display("FAIL wait retire: got v=%b data=%h d=%h rw=%b err=%b exp 1 12345678 6 1 0", bus.wb_valid, bus.wb_data, bus.wb_reg_dest, bus.wb_reg_wr, bus.err); end
    tick();
    vec++; if (bus.wb_valid !== 1'b0) begin miss++; $display("FAIL wait single pulse: got %b exp 0", bus.wb_valid); end
  endtask

  task automatic test_misaligned();
    drive_op(32'h0, 32'h102, 32'h0, 4'h7, 1'b1, 1'b1, 1'b0);
    tick(); drive_idle();
    vec++; if (bus.dm_req !== 1'b0 || bus.ex_ready !== 1'b1) begin miss++; $display("FAIL misalign no req: got req=%b rdy=%b exp 0 1", bus.dm_req, bus.ex_ready); end
    vec++; if (bus.err !== 1'b1 || bus.wb_valid !== 1'b1 || bus.wb_reg_wr !== 1'b0)
      begin miss++; $display("FAIL misalign retire: got err=%b v=%b rw=%b exp 1 1 0", bus.err, bus.wb_valid, bus.wb_reg_wr); end
    tick();
    vec++; if (bus.err !== 1'b0 || bus.wb_valid !== 1'b0 || bus.dm_req !== 1'b0)
      begin miss++; $display("FAIL misalign pulse: got err=%b v=%b req=%b exp 0 0 0", bus.err, bus.wb_valid, bus.dm_req); end
  endtask

  task automatic test_rd_wr_both();
    drive_op(32'h0, 32'h600, 32'h0000A5A5, 4'h8, 1'b1, 1'b1, 1'b1);
    tick(); drive_idle();
    vec++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b1 || bus.dm_wdata !== 32'h0000A5A5)
      begin miss++; $display("FAIL rd+wr req: got req=%b we=%b d=%h exp 1 1 0000a5a5", bus.dm_req, bus.dm_we, bus.dm_wdata); end
    bus.dm_gnt = 1; tick(); bus.dm_gnt = 0;
    vec++; if (bus.wb_valid !== 1'b1 || bus.wb_reg_wr !== 1'b0 || bus.err !== 1'b0)
      begin miss++; $display("FAIL rd+wr retire: got v=%b rw=%b err=%b exp 1 0 0", bus.wb_valid, bus.wb_reg_wr, bus.err); end
    tick();
  endtask

  task automatic test_timeout();
    drive_op(32'h0, 32'h400, 32'h0, 4'h9, 1'b1, 1'b1, 1'b0);
    tick(); drive_idle();
    for (int k = 1; k <= 8; k++) begin
      vec++; if (bus.err !== 1'b0 || bus.wb_valid !== 1'b0 || bus.dm_req !== 1'b1)
        begin miss++; $display("FAIL timeout early cyc%0d: got err=%b v=%b req=%b exp 0 0 1", k, bus.err, bus.wb_valid, bus.dm_req); end
      tick();
    end
    vec++; if (bus.err !== 1'b1 || bus.wb_valid !== 1'b1 || bus.wb_reg_wr !== 1'b0 || bus.wb_data !== 32'h0)
      begin miss++; $display("FAIL timeout retire: got err=%b v=%b rw=%b data=%h exp 1 1 0 0", bus.err, bus.wb_valid, bus.wb_reg_wr, bus.wb_data); end
    vec++; if (bus.dm_req !== 1'b0 || bus.ex_ready !== 1'b1) begin miss++; $display("FAIL timeout idle: got req=%b rdy=%b exp 0 1", bus.dm_req, bus.ex_ready); end
    tick();
    vec++; if (bus.err !== 1'b0 || bus.wb_valid !== 1'b0) begin miss++; $display("FAIL timeout pulse: got err=%b v=%b exp 0 0", bus.err, bus.wb_valid); end
  endtask

  task automatic test_reset_in_wait();
    drive_op(32'h0, 32'h500, 32'h0, 4'hA, 1'b1, 1'b1, 1'b0);
    tick(); drive_idle();
    bus.dm_gnt = 1; tick(); bus.dm_gnt = 0;
    vec++; if (bus.dm_req !== 1'b0 || bus.ex_ready !== 1'b0) begin miss++; $display("FAIL rstwait in WAIT: got req=%b rdy=%b exp 0 0", bus.dm_req, bus.ex_ready); end
    rst = 1; tick(); rst = 0;
    vec++; if (bus.ex_ready !== 1'b1 || bus.dm_req !== 1'b0 || bus.dm_we !== 1'b0 || bus.dm_addr !== 32'h0 || bus.dm_wdata !== 32'h0)
      begin miss++; $display("FAIL rstwait dm side: got rdy=%b req=%b we=%b a=%h d=%h exp 1 0 0 0 0", bus.ex_ready, bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_wdata); end
    vec++; if (bus.wb_valid !== 1'b0 || bus.wb_reg_wr !== 1'b0 || bus.wb_reg_dest !== 4'h0 || bus.wb_data !== 32'h0 || bus.err !== 1'b0)
      begin miss++; $display("FAIL rstwait wb side: got v=%b rw=%b d=%h data=%h err=%b exp 0 0 0 0 0", bus.wb_valid, bus.wb_reg_wr, bus.wb_reg_dest, bus.wb_data, bus.err); end
    bus.dm_gnt = 1; bus.dm_rvalid = 1; bus.dm_rdata = 32'hFEEDFACE;
    tick();
    bus.dm_gnt = 0; bus.dm_rvalid = 0; bus.dm_rdata = '0;
    vec++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h0 || bus.dm_req !== 1'b0)
      begin miss++; $display("FAIL late rvalid: got v=%b data=%h req=%b exp 0 0 0", bus.wb_valid, bus.wb_data, bus.dm_req); end
    for (int k = 0; k < 10; k++) tick();
    vec++; if (bus.err !== 1'b0 || bus.wb_valid !== 1'b0) begin miss++; $display("FAIL no stale timeout: got err=%b v=%b exp 0 0", bus.err, bus.wb_valid); end
  endtask

  initial begin
    test_reset();
    test_alu_passthru();
    test_store_delayed_gnt();
    test_load_same_cycle();
    test_load_wait();
    test_misaligned();
    test_rd_wr_both();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of Execute.
- Accepts one op per handshake from Execute: ALU result, memory address/data, destination register, control bits.
- Runs the data-memory request/response handshake, then retires one result per op to Writeback.
- Drives the forwarding path back to Execute and stalls Execute while a memory access is in flight.

Parameters:
- DATA_W, 32, data/address width.
- REG_W, 4, destination register index width.
- TIMEOUT_CYC, 64, max cycles in REQ+WAIT before abandoning an access (range 2..255).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ex_valid  in  1  Execute presents an op.
- ex_ready  out  1  stage can accept an op; high only in IDLE.
- ex_alu_out  in  DATA_W  ALU result.
- ex_mem_addr  in  DATA_W  memory address.
- ex_mem_data  in  DATA_W  store data.
- ex_reg_dest  in  REG_W  destination register.
- ex_reg_wr  in  1  op writes a register.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- dm_req  out  1  memory request.
- dm_we  out  1  request is a store.
- dm_addr  out  DATA_W  request address.
- dm_wdata  out  DATA_W  store data.
- dm_gnt  in  1  request accepted.
- dm_rvalid  in  1  load data valid.
- dm_rdata  in  DATA_W  load data.
- wb_valid  out  1  one-cycle retire pulse.
- wb_reg_wr  out  1  retired op writes wb_reg_dest.
- wb_reg_dest  out  REG_W  destination register.
- wb_data  out  DATA_W  result.
- fwd_valid  out  1  equals wb_valid & wb_reg_wr (combinational).
- fwd_dest  out  REG_W  equals wb_reg_dest.
- fwd_data  out  DATA_W  equals wb_data.
- err  out  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset:
  - state=IDLE; held op registers cleared; timer=0.
  - ex_ready=1 once IDLE; dm_req=0; dm_we=0; dm_addr=0; dm_wdata=0.
  - wb_valid=0; wb_reg_wr=0; wb_reg_dest=0; wb_data=0; err=0.
- Accept: edge with ex_valid & ex_ready. Op fields are latched into hold registers.
- Non-memory op (mem_rd=mem_wr=0):
  - wb_* are loaded at the accept edge; wb_valid=1 the following cycle.
  - wb_data=ex_alu_out; state stays IDLE; throughput 1 op/cycle.
- Memory op, address aligned (addr[1:0]==0):
  - State goes to REQ; wb_valid=0 that cycle.
  - mem_wr & mem_rd both set: treated as a store, no err.
- Misaligned memory op:
  - No dm request is issued; state stays IDLE.
  - Next cycle: err=1, wb_valid=1, wb_reg_wr=0.
- States:
  - IDLE: ex_ready=1, dm_req=0.
  - REQ: dm_req=1 with dm_we/dm_addr/dm_wdata from hold registers, stable until dm_gnt.
    - Store & gnt: retire next cycle (wb_valid=1, wb_reg_wr=0); go to IDLE.
    - Load & gnt & rvalid same edge: retire with dm_rdata; go to IDLE.
    - Load & gnt without rvalid: go to WAIT.
    - dm_rvalid without gnt in REQ is ignored.
  - WAIT: dm_req=0. On dm_rvalid: wb_data=dm_rdata, wb_reg_wr=held reg_wr, wb_valid=1 next cycle; go to IDLE.
- Timer:
  - Clears on entry to REQ; increments every cycle in REQ or WAIT.
  - When timer reaches TIMEOUT_CYC-1 with no completing event: go to IDLE; next cycle err=1, wb_valid=1, wb_reg_wr=0, wb_data=0.
  - A completing event on that same edge wins; no err.
- Pulse widths: wb_valid and err are single-cycle. Writeback has no backpressure.
- New ops are accepted only in IDLE, so the earliest accept after a memory retire is the retire edge's next cycle.
- Reset mid-access: dm_req drops the cycle after the reset edge. Late dm_gnt/dm_rvalid arriving in IDLE are ignored.
- Loads use full-word width only; no byte or half-word lanes.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {IDLE, REQ, WAIT};
  - DATA_W/REG_W defaults;
  - ALIGN_MASK=2'b11;
  - TIMEOUT_CYC default.
- One sub-module, mem_timeout_ctr: clear/enable inputs, `expired` output, width $clog2(TIMEOUT_CYC).

Test Plan:
- ALU pass-through: three back-to-back ops (dest 1/2/3, alu 0x11/0x22/0x33) -> wb_valid on 3 consecutive cycles, ex_ready held 1, fwd_data tracks wb_data.
- Store, gnt delayed 3 cycles (addr 0x100, data 0xDEADBEEF) -> dm_req/dm_we/dm_addr/dm_wdata stable 4 cycles, ex_ready=0, single wb_valid with wb_reg_wr=0.
- Load, gnt+rvalid same cycle, rdata 0xCAFEF00D, dest 5 -> wb_valid one cycle later with wb_data=0xCAFEF00D, fwd_valid=1, fwd_dest=5.
- Load, rvalid 5 cycles after gnt -> state WAIT, dm_req=0 after gnt, single retire with correct data.
- Misaligned load at 0x102 -> no dm_req; next cycle err=1, wb_valid=1, wb_reg_wr=0.
- Timeout (TIMEOUT_CYC=8, gnt never): err pulse and retire with wb_data=0 exactly 8 cycles after entering REQ. Repeat with rst asserted in WAIT -> all outputs at reset values; a late rvalid is ignored.
